// File: rtl/nano_status_uart.sv
// rtl/nano_status_uart.sv - sweeps OUT_CTRL through all codes and streams the sampled monitor outputs as 8N1 UART bytes
// Define MON_CHECKSUM_EN to append an XOR byte over the 16 data bytes after B7.
module nano_status_uart #(
    parameter int CLKS_PER_BIT = 163,
    parameter int SETTLE_CYC   = 2
) (
    input  logic       CLK,
    input  logic       NRST,
    input  logic       START,
    input  logic [7:0] OUT8B_I,
    input  logic [3:0] OUT4B_I,
    output logic [2:0] OUT_CTRL,
    output logic       TX,
    output logic       BUSY,
    output logic       DONE
);
    localparam logic [9:0] BAUD_LAST   = 10'(CLKS_PER_BIT - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC);
    localparam logic [7:0] SYNC_BYTE   = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SEL_SETTLE,
        SEND_A,
        SEND_B,
`ifdef MON_CHECKSUM_EN
        CHK,
`endif
        FIN
    } state_t;

    state_t     state, state_d;
    logic       start_q;
    logic [2:0] sel, sel_d;
    logic [9:0] baud_cnt, baud_d;
    logic [3:0] bit_idx, bit_d;
    logic [3:0] settle_cnt, settle_d;
    logic [7:0] byte_a, byte_a_d;
    logic [7:0] byte_b, byte_b_d;
    logic [7:0] byte_b_cap;
    logic [7:0] cur_byte;
    logic [2:0] out_ctrl_d;
    logic       tx_d, busy_d, done_d;
    logic       sending, byte_end;
`ifdef MON_CHECKSUM_EN
    logic [7:0] csum, csum_d;
`endif

    assign byte_b_cap = {1'b0, sel, OUT4B_I};

    always_comb begin
        state_d    = state;
        sel_d      = sel;
        baud_d     = baud_cnt;
        bit_d      = bit_idx;
        settle_d   = settle_cnt;
        byte_a_d   = byte_a;
        byte_b_d   = byte_b;
        tx_d       = TX;
        busy_d     = BUSY;
        done_d     = 1'b0;
        out_ctrl_d = OUT_CTRL;
`ifdef MON_CHECKSUM_EN
        csum_d     = csum;
`endif
        sending    = 1'b0;
        byte_end   = 1'b0;
        cur_byte   = SYNC_BYTE;

        case (state)
            SYNC:   sending = 1'b1;
            SEND_A: begin sending = 1'b1; cur_byte = byte_a; end
            SEND_B: begin sending = 1'b1; cur_byte = byte_b; end
`ifdef MON_CHECKSUM_EN
            CHK:    begin sending = 1'b1; cur_byte = csum; end
`endif
            default: ;
        endcase

        // bit_idx: 0 = start bit, 1..8 = data LSB first, 9 = stop bit
        if (sending) begin
            if (baud_cnt == BAUD_LAST) begin
                baud_d = '0;
                if (bit_idx == 4'd9) begin
                    byte_end = 1'b1;
                    bit_d    = '0;
                end else begin
                    bit_d = bit_idx + 4'd1;
                    tx_d  = (bit_idx == 4'd8) ? 1'b1 : cur_byte[bit_idx[2:0]];
                end
            end else begin
                baud_d = baud_cnt + 10'd1;
            end
        end

        case (state)
            IDLE: begin
                if (START && !start_q) begin
                    state_d = SYNC;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    bit_d   = '0;
                    sel_d   = '0;
`ifdef MON_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            SYNC: begin
                if (byte_end) begin
                    state_d    = SEL_SETTLE;
                    tx_d       = 1'b1;
                    out_ctrl_d = sel;
                    settle_d   = '0;
                end
            end
            SEL_SETTLE: begin
                // OUT_CTRL has been stable for SETTLE_CYC + 1 cycles when the capture happens
                if (settle_cnt == SETTLE_LAST) begin
                    state_d  = SEND_A;
                    byte_a_d = OUT8B_I;
                    byte_b_d = byte_b_cap;
`ifdef MON_CHECKSUM_EN
                    csum_d   = csum ^ OUT8B_I ^ byte_b_cap;
`endif
                    tx_d     = 1'b0;
                end else begin
                    settle_d = settle_cnt + 4'd1;
                end
            end
            SEND_A: begin
                if (byte_end) begin
                    state_d = SEND_B;
                    tx_d    = 1'b0;
                end
            end
            SEND_B: begin
                if (byte_end) begin
                    if (sel != 3'd7) begin
                        state_d    = SEL_SETTLE;
                        sel_d      = sel + 3'd1;
                        out_ctrl_d = sel + 3'd1;
                        settle_d   = '0;
                        tx_d       = 1'b1;
                    end else begin
`ifdef MON_CHECKSUM_EN
                        state_d = CHK;
                        tx_d    = 1'b0;
`else
                        state_d    = FIN;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        out_ctrl_d = '0;
                        sel_d      = '0;
                        tx_d       = 1'b1;
`endif
                    end
                end
            end
`ifdef MON_CHECKSUM_EN
            CHK: begin
                if (byte_end) begin
                    state_d    = FIN;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    out_ctrl_d = '0;
                    sel_d      = '0;
                    tx_d       = 1'b1;
                end
            end
`endif
            // DONE is high while in FIN, so a START rise here is ignored
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state      <= IDLE;
            start_q    <= 1'b0;
            sel        <= '0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            settle_cnt <= '0;
            byte_a     <= '0;
            byte_b     <= '0;
            TX         <= 1'b1;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            OUT_CTRL   <= '0;
`ifdef MON_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            state      <= state_d;
            start_q    <= START;
            sel        <= sel_d;
            baud_cnt   <= baud_d;
            bit_idx    <= bit_d;
            settle_cnt <= settle_d;
            byte_a     <= byte_a_d;
            byte_b     <= byte_b_d;
            TX         <= tx_d;
            BUSY       <= busy_d;
            DONE       <= done_d;
            OUT_CTRL   <= out_ctrl_d;
`ifdef MON_CHECKSUM_EN
            csum       <= csum_d;
`endif
        end
    end

endmodule
